// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_MAX_BURST = 16;

endpackage

// File: rtl/mux2_reg.sv
// WIDTH-wide 2:1 select with registered data and a beat-valid flag.
module mux2_reg
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  output logic [WIDTH-1:0] mux_out,
  output logic             mux_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_out   <= '0;
      mux_valid <= 1'b0;
    end else begin
      mux_valid <= en;
      if (en) mux_out <= sel ? din_1 : din_0;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester burst arbiter: round-robin grant FSM, burst limiter, registered mux.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic             req_1,
  input  logic             last_0,
  input  logic             last_1,
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             sel,
  output logic [WIDTH-1:0] mux_out,
  output logic             mux_valid
);

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  arb_state_t state, next_state;
  logic       prio;
  logic [7:0] cnt;

  logic own, req_own, req_oth, last_own;
  logic beat, end_last, end_force, grant_end, grant_start;

  always_comb begin
    next_state = state;
    own        = (state == GNT1);
    req_own    = own ? req_1 : req_0;
    req_oth    = own ? req_0 : req_1;
    last_own   = own ? last_1 : last_0;
    beat       = 1'b0;
    end_last   = 1'b0;
    end_force  = 1'b0;
    grant_end  = 1'b0;
    case (state)
      IDLE: begin
        if (req_0 && req_1) next_state = prio ? GNT1 : GNT0;
        else if (req_0)     next_state = GNT0;
        else if (req_1)     next_state = GNT1;
      end
      GNT0, GNT1: begin
        beat      = req_own;
        end_last  = beat && last_own;
        // cnt holds beats already taken, so this beat is number cnt+1
        end_force = beat && req_oth && (cnt >= MAXB - 8'd1);
        grant_end = !req_own || end_last || end_force;
        if (grant_end) begin
          if (req_oth)       next_state = own ? GNT0 : GNT1;
          else if (end_last) next_state = state;
          else               next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    grant_start = (next_state != IDLE) && ((next_state != state) || grant_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
      sel   <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_end) prio <= ~own;
      if (grant_start)                cnt <= '0;
      else if (beat && (cnt != MAXB)) cnt <= cnt + 8'd1;
      if (next_state != IDLE) sel <= (next_state == GNT1);
    end
  end

  assign gnt_0 = (state == GNT0);
  assign gnt_1 = (state == GNT1);

  mux2_reg #(.WIDTH(WIDTH)) u_mux2_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (beat),
    .sel      (own),
    .din_0    (din_0),
    .din_1    (din_1),
    .mux_out  (mux_out),
    .mux_valid(mux_valid)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (burst limit 4 and 16) share stimulus and are
// compared each cycle against a behavioural model, plus directed literal checks.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_0 = 1'b0, req_1 = 1'b0, last_0 = 1'b0, last_1 = 1'b0;
  logic [7:0] din_0 = '0, din_1 = '0;

  logic       gnt_0[2], gnt_1[2], sel[2], mux_valid[2];
  logic [7:0] mux_out[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .last_0(last_0), .last_1(last_1),
    .din_0(din_0), .din_1(din_1), .gnt_0(gnt_0[0]), .gnt_1(gnt_1[0]), .sel(sel[0]),
    .mux_out(mux_out[0]), .mux_valid(mux_valid[0]));

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .last_0(last_0), .last_1(last_1),
    .din_0(din_0), .din_1(din_1), .gnt_0(gnt_0[1]), .gnt_1(gnt_1[1]), .sel(sel[1]),
    .mux_out(mux_out[1]), .mux_valid(mux_valid[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner -1 = nobody, else index of granted requester.
  int         m_owner[2], m_prio[2], m_beats[2], m_sel[2], m_val[2];
  logic [7:0] m_out[2];
  int         maxb[2] = '{4, 16};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = -1; m_prio[k] = 0; m_beats[k] = 0; m_sel[k] = 0; m_val[k] = 0; m_out[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int r[2], l[2], nxt, x, o;
        logic [7:0] d[2];
        r[0] = int'(req_0); r[1] = int'(req_1);
        l[0] = int'(last_0); l[1] = int'(last_1);
        d[0] = din_0; d[1] = din_1;
        nxt = m_owner[k];
        m_val[k] = 0;
        if (m_owner[k] < 0) begin
          if (r[0] == 1 && r[1] == 1) nxt = m_prio[k];
          else if (r[0] == 1)         nxt = 0;
          else if (r[1] == 1)         nxt = 1;
          if (nxt >= 0) m_beats[k] = 0;
        end else begin
          x = m_owner[k]; o = 1 - x;
          if (r[x] == 1) begin
            m_val[k] = 1; m_out[k] = d[x]; m_beats[k]++;
          end
          if (r[x] == 0 || l[x] == 1 || (m_beats[k] >= maxb[k] && r[o] == 1)) begin
            m_prio[k] = o;
            if (r[o] == 1)                   nxt = o;
            else if (r[x] == 1 && l[x] == 1) nxt = x;
            else                             nxt = -1;
            m_beats[k] = 0;
          end
        end
        m_owner[k] = nxt;
        if (nxt >= 0) m_sel[k] = nxt;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt_0[%0d]", k), 32'(gnt_0[k]), 32'(m_owner[k] == 0));
      chk($sformatf("gnt_1[%0d]", k), 32'(gnt_1[k]), 32'(m_owner[k] == 1));
      chk($sformatf("sel[%0d]", k), 32'(sel[k]), 32'(m_sel[k]));
      chk($sformatf("mux_valid[%0d]", k), 32'(mux_valid[k]), 32'(m_val[k]));
      if (m_val[k] == 1) chk($sformatf("mux_out[%0d]", k), 32'(mux_out[k]), 32'(m_out[k]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_gnt0"}, 32'(gnt_0[k]), 0);
      chk({tag, "_gnt1"}, 32'(gnt_1[k]), 0);
      chk({tag, "_sel"}, 32'(sel[k]), 0);
      chk({tag, "_out"}, 32'(mux_out[k]), 0);
      chk({tag, "_valid"}, 32'(mux_valid[k]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats_a, guard;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Simultaneous requests: requester 0 preferred, then handover without gap.
    tick();
    req_0 = 1; req_1 = 1; din_0 = 8'h11;
    tick();
    chk("sim_gnt0", 32'(gnt_0[0]), 1); chk("sim_sel", 32'(sel[0]), 0);
    chk("sim_gnt1_low", 32'(gnt_1[0]), 0);
    last_0 = 1; din_0 = 8'h22;
    tick();
    chk("handover_gnt1", 32'(gnt_1[0]), 1); chk("handover_sel", 32'(sel[0]), 1);
    chk("handover_out", 32'(mux_out[0]), 32'h22);

    // Data latency in GNT1.
    last_0 = 0; req_0 = 0; din_1 = 8'hA5; last_1 = 1;
    tick();
    chk("lat_out", 32'(mux_out[0]), 32'hA5); chk("lat_valid", 32'(mux_valid[0]), 1);
    chk("lat_regrant", 32'(gnt_1[0]), 1);
    req_1 = 0; last_1 = 0;
    tick();
    chk("drop1_idle", 32'(gnt_1[0]), 0); chk("drop1_valid", 32'(mux_valid[0]), 0);

    // Forced release after 4 beats on the MAX_BURST=4 instance.
    req_0 = 1; req_1 = 1;
    tick();
    chk("force_start", 32'(gnt_0[0]), 1);
    beats_a = 0; guard = 0;
    while (gnt_1[0] !== 1'b1 && guard < 20) begin
      if (gnt_0[0] === 1'b1) beats_a++;
      din_0 = 8'(8'h40 + guard);
      guard++;
      tick();
    end
    chk("force_beats", 32'(beats_a), 4);
    chk("force_valid", 32'(mux_valid[0]), 1);
    chk("force_last_data", 32'(mux_out[0]), 32'h43);
    req_0 = 0; req_1 = 0;
    tick(); tick();

    // Unlimited burst with the other requester idle.
    req_0 = 1;
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("unlim_gnt0_b", 32'(gnt_0[1]), 1);
      chk("unlim_gnt0_a", 32'(gnt_0[0]), 1);
      din_0 = 8'(i * 3);
      tick();
    end
    req_0 = 0;
    tick(); tick();

    // Mid-burst reset in GNT1.
    req_1 = 1; din_1 = 8'h5C;
    tick(); tick();
    chk("pre_rst_gnt1", 32'(gnt_1[1]), 1);
    #2 rst_n = 0;
    #1 chk_all_zero("async_rst");
    req_0 = 1; req_1 = 1;
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_gnt0_a", 32'(gnt_0[0]), 1); chk("post_rst_gnt0_b", 32'(gnt_0[1]), 1);

    // Dropped request in GNT0 with requester 1 idle.
    req_1 = 0;
    tick();
    req_0 = 0;
    tick();
    chk("drop0_gnt0", 32'(gnt_0[1]), 0); chk("drop0_gnt1", 32'(gnt_1[1]), 0);
    chk("drop0_valid", 32'(mux_valid[1]), 0); chk("drop0_sel", 32'(sel[1]), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
